// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
// Shared definitions for the data-memory responder and the core's control
// unit: memory access-size encodings, error-cause bit positions, the lane
// count and the sign-extension helpers used on load data.
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

  // Access-size encodings on D_MEM_memMode (shared with the core's CU)
  localparam logic [1:0] MEM_MODE_BYTE    = 2'b00;
  localparam logic [1:0] MEM_MODE_HALF    = 2'b01;
  localparam logic [1:0] MEM_MODE_WORD    = 2'b10;
  localparam logic [1:0] MEM_MODE_ILLEGAL = 2'b11;

  // Bit positions inside the 3-bit err_cause vector
  localparam int ERR_BIT_MISALIGNED = 0;
  localparam int ERR_BIT_RANGE      = 1;
  localparam int ERR_BIT_ILLEGAL    = 2;

  // Byte lanes per 32-bit word
  localparam int DMEM_LANES = 4;

  // Sign-extend a byte to a 32-bit word
  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  // Sign-extend a halfword to a 32-bit word
  function automatic logic [31:0] sext16(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/dmem_lane_ctl.sv
// -----------------------------------------------------------------------------
// dmem_lane_ctl
// Combinational lane steering for a 32-bit little-endian data memory.
// Ports:
//   i_mode       access size (byte/half/word/illegal)
//   i_off        byte offset addr[1:0]
//   i_wdata      right-aligned store data
//   i_rword      raw word read from the array
//   o_lane_en    byte-lane write enables (zero for illegal mode)
//   o_misaligned alignment violation for the given size/offset
//   o_wdata_rep  store data replicated across all lanes
//   o_rdata      extracted and sign-extended load result
// -----------------------------------------------------------------------------
module dmem_lane_ctl
  import dmem_responder_pkg::*;
(
  input  logic [1:0]            i_mode,
  input  logic [1:0]            i_off,
  input  logic [31:0]           i_wdata,
  input  logic [31:0]           i_rword,
  output logic [DMEM_LANES-1:0] o_lane_en,
  output logic                  o_misaligned,
  output logic [31:0]           o_wdata_rep,
  output logic [31:0]           o_rdata
);

  // Addressed byte/half shifted down to bit 0
  logic [15:0] w_sh;
  assign w_sh = 16'(i_rword >> {i_off, 3'b000});

  // Decode lane enables, alignment, write replication and read extraction
  always_comb begin
    o_lane_en    = 4'b0000;
    o_misaligned = 1'b0;
    o_wdata_rep  = 32'h0000_0000;
    o_rdata      = 32'h0000_0000;
    case (i_mode)
      MEM_MODE_BYTE: begin
        o_lane_en   = 4'b0001 << i_off;
        o_wdata_rep = {4{i_wdata[7:0]}};
        o_rdata     = sext8(w_sh[7:0]);
      end
      MEM_MODE_HALF: begin
        o_misaligned = i_off[0];
        o_lane_en    = 4'b0011 << i_off;
        o_wdata_rep  = {2{i_wdata[15:0]}};
        o_rdata      = sext16(w_sh);
      end
      MEM_MODE_WORD: begin
        o_misaligned = |i_off;
        o_lane_en    = 4'b1111;
        o_wdata_rep  = i_wdata;
        o_rdata      = i_rword;
      end
      default: begin
        // Illegal mode: no lanes; the fault is flagged by the top
        o_lane_en    = 4'b0000;
        o_misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Byte-addressable, little-endian, word-organised data memory serving the
// core's load/store port. Loads are registered (1-cycle latency) and
// sign-extended; stores are lane-masked. Misaligned, out-of-range, illegal
// mode and read/write-conflict accesses are suppressed and the first one is
// captured in sticky error registers until err_clr.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   D_MEM_addr          byte address
//   D_MEM_dataIn        right-aligned store data
//   D_MEM_memRead/Write load / store strobes
//   D_MEM_memMode       00 byte, 01 half, 10 word, 11 illegal
//   D_MEM_dataOut       registered load result
//   err_valid/cause/addr sticky first-fault record; err_clr clears it
// Macros:
//   DMEM_LOADER_EN      adds ld_en/ld_word_idx/ld_data full-word loader port;
//                       core strobes are ignored while ld_en=1
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_WIDTH  = 32,
  parameter int WORD_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_WIDTH-1:0]  D_MEM_addr,
  input  logic [WORD_WIDTH-1:0]  D_MEM_dataIn,
  input  logic                   D_MEM_memRead,
  input  logic                   D_MEM_memWrite,
  input  logic [1:0]             D_MEM_memMode,
  output logic [WORD_WIDTH-1:0]  D_MEM_dataOut,
  output logic                   err_valid,
  output logic [2:0]             err_cause,
  output logic [ADDR_WIDTH-1:0]  err_addr,
`ifdef DMEM_LOADER_EN
  input  logic                   ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_word_idx,
  input  logic [31:0]            ld_data,
`endif
  input  logic                   err_clr
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [WORD_WIDTH-1:0] r_dout;
  logic                  r_err_valid;
  logic [2:0]            r_err_cause;
  logic [ADDR_WIDTH-1:0] r_err_addr;

`ifdef DMEM_LOADER_EN
  logic w_ld_active;
  assign w_ld_active = ld_en;
`else
  logic w_ld_active;
  assign w_ld_active = 1'b0;
`endif

  // Core strobes are masked while the loader owns the array
  logic w_rd, w_wr, w_any;
  assign w_rd  = D_MEM_memRead  & ~w_ld_active;
  assign w_wr  = D_MEM_memWrite & ~w_ld_active;
  assign w_any = w_rd | w_wr;

  logic [IDX_W-1:0] w_idx;
  logic             w_oor;
  assign w_idx = D_MEM_addr[IDX_W+1:2];
  assign w_oor = |D_MEM_addr[ADDR_WIDTH-1:IDX_W+2];

  logic [DMEM_LANES-1:0] w_lane_en;
  logic                  w_misaligned;
  logic [31:0]           w_wdata_rep;
  logic [31:0]           w_rdata;

  dmem_lane_ctl u_lane_ctl (
    .i_mode       (D_MEM_memMode),
    .i_off        (D_MEM_addr[1:0]),
    .i_wdata      (D_MEM_dataIn),
    .i_rword      (r_mem[w_idx]),
    .o_lane_en    (w_lane_en),
    .o_misaligned (w_misaligned),
    .o_wdata_rep  (w_wdata_rep),
    .o_rdata      (w_rdata)
  );

  // Fault classification; a strobe-free cycle never faults
  logic [2:0] w_cause;
  logic       w_fault, w_do_store, w_do_load;
  assign w_cause[ERR_BIT_MISALIGNED] = w_any & w_misaligned;
  assign w_cause[ERR_BIT_RANGE]      = w_any & w_oor;
  assign w_cause[ERR_BIT_ILLEGAL]    = w_any & ((w_rd & w_wr) |
                                       (D_MEM_memMode == MEM_MODE_ILLEGAL));
  assign w_fault    = |w_cause;
  assign w_do_store = w_wr & ~w_fault;
  assign w_do_load  = w_rd & ~w_fault;

  // Array write port: loader full-word writes, else lane-masked core stores.
  // rst_n gating drops a store issued while reset is asserted.
  always_ff @(posedge clk) begin
`ifdef DMEM_LOADER_EN
    if (rst_n && ld_en) begin
      r_mem[ld_word_idx] <= ld_data;
    end else
`endif
    if (rst_n && w_do_store) begin
      for (int b = 0; b < DMEM_LANES; b++) begin
        if (w_lane_en[b]) begin
          r_mem[w_idx][b*8 +: 8] <= w_wdata_rep[b*8 +: 8];
        end
      end
    end
  end

  // Registered load result; holds on no-read or suppressed read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= '0;
    end else if (w_do_load) begin
      r_dout <= WORD_WIDTH'(w_rdata);
    end
  end

  // Sticky first-fault capture; a new fault beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_valid <= 1'b0;
      r_err_cause <= 3'b000;
      r_err_addr  <= '0;
    end else if (w_fault && (!r_err_valid || err_clr)) begin
      r_err_valid <= 1'b1;
      r_err_cause <= w_cause;
      r_err_addr  <= D_MEM_addr;
    end else if (err_clr) begin
      r_err_valid <= 1'b0;
      r_err_cause <= 3'b000;
      r_err_addr  <= '0;
    end
  end

  assign D_MEM_dataOut = r_dout;
  assign err_valid     = r_err_valid;
  assign err_cause     = r_err_cause;
  assign err_addr      = r_err_addr;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Synchronous data-memory target that services the core's load/store port: address, write data, read/write strobes, 2-bit memory mode and read data.
- Byte-addressable, little-endian, word-organised array.
- Registered read data (1-cycle latency), so the core samples it in its writeback stage.
- Stores are byte-lane masked; misaligned, out-of-range and illegal-mode accesses are suppressed and logged in sticky error registers.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two, >= 2.
ADDR_WIDTH, 32, width of the byte address from the core.
WORD_WIDTH, 32, data width; fixed at 32.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
D_MEM_addr  in  ADDR_WIDTH  byte address of the access.
D_MEM_dataIn  in  WORD_WIDTH  store data, right-aligned: byte in [7:0], half in [15:0].
D_MEM_memRead  in  1  load strobe.
D_MEM_memWrite  in  1  store strobe.
D_MEM_memMode  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
D_MEM_dataOut  out  WORD_WIDTH  registered, sign-extended load result.
err_valid  out  1  sticky; set by the first faulting access.
err_cause  out  3  sticky cause: bit0 misaligned, bit1 out-of-range, bit2 illegal mode/strobe conflict.
err_addr  out  ADDR_WIDTH  address of the first faulting access.
err_clr  in  1  synchronous clear of err_valid, err_cause and err_addr.

Behaviour:
- Reset values: D_MEM_dataOut=0, err_valid=0, err_cause=0, err_addr=0. Array contents are not reset.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Byte offset = addr[1:0].
- Out-of-range: any address bit above index MSB is set. The access is suppressed; no wrap-around.
- Alignment rules:
  - half requires addr[0]=0;
  - word requires addr[1:0]=00;
  - a violation is a misaligned fault and the access is suppressed.
- Store: on the edge where memWrite=1 and the access is legal, write the enabled byte lanes.
  - Lane enables: byte 4'b0001<<off; half 4'b0011<<off; word 4'b1111.
  - Data is replicated onto the lanes; disabled lanes are unchanged.
- Load: on the edge where memRead=1 and the access is legal, D_MEM_dataOut <= the selected byte/half/word.
  - Byte and half results are sign-extended to 32 bits.
  - Result is visible the cycle after the strobe; latency exactly 1.
- With no read, or a suppressed read, D_MEM_dataOut holds its previous value.
- memRead=1 and memWrite=1 together: cause bit2, both suppressed, dataOut holds.
- mode=11 with either strobe: cause bit2, access suppressed.
- A strobe-free cycle never faults, whatever the address or mode.
- Error capture:
  - first fault with err_valid=0 loads err_valid=1, err_cause (all applicable bits) and err_addr;
  - later faults are ignored until err_clr;
  - err_clr and a new fault in the same cycle: the fault wins, so the new fault is captured.
- Back-to-back store then load to the same address: the load returns the new data; no bypass needed, since the write commits on the earlier edge.
- Reset asserted mid-operation: outputs return to reset values immediately; a pending store in that cycle is dropped.

Optional Feature:
DMEM_LOADER_EN
- Defined: adds ports ld_en (in,1), ld_word_idx (in, log2(DEPTH_WORDS)), ld_data (in,32).
  - While ld_en=1, a full-word write to ld_word_idx occurs each edge.
  - Core strobes are ignored and never fault while ld_en=1; D_MEM_dataOut holds.
- Undefined: the ports are absent; the array is initialised only by simulation $readmemh of a file named by the DMEM_INIT_FILE string macro, or left uninitialised.

Decomposition:
- Shared defines package:
  - MEM_MODE_BYTE, MEM_MODE_HALF, MEM_MODE_WORD, MEM_MODE_ILLEGAL;
  - the 3-bit error-cause bit positions;
  - DMEM_LANES=4.
  The core's CU uses the same mode constants.
- Sub-module dmem_lane_ctl (combinational): takes mode + offset and produces lane enables, misaligned flag, replicated write data and the extracted/sign-extended read word.
- The top holds the array, output register and error registers.

Test Plan:
- Reset then word store 0xDEADBEEF at 0x10, load word at 0x10 -> dataOut=0xDEADBEEF exactly 1 cycle after memRead; 0 before.
- Byte store 0x80 at 0x13 over 0x00000000, load word 0x10 -> 0x80000000; load byte 0x13 -> 0xFFFFFF80.
- Half store 0x1234 at 0x22, load half 0x22 -> 0x00001234; load half 0x20 -> 0x00000000 (lanes 0-1 untouched).
- Word load at 0x06 -> err_valid=1, err_cause=001, err_addr=0x06, dataOut unchanged; second fault at 0x5 leaves err_addr=0x06; err_clr -> all zero.
- Store at DEPTH_WORDS*4 -> cause=010, no array word modified (verify by reading index 0 and last index).
- memRead and memWrite both set at 0x0 -> cause=100, memory unchanged; rst_n pulsed mid-burst -> dataOut=0, err_valid=0 asynchronously.
